bb_quant_pack: RTL and testbench
================================

// Module: bb_quant_pack
// PURPOSE
//  Downstream of the GPS emulator summing/noise stage. Takes the 16-bit complex baseband.
//  Quantizes each rail to 2-bit sign/magnitude, as a MAX2769-style front end does.
//  An AGC loop adapts the magnitude threshold. Packs 8 complex samples per 32-bit word
//  onto a valid/ready stream for the capture FIFO/DMA, with overflow accounting.
//  Also provides an unpacked 2-bit tap for direct correlator use.
// PARAMETERS
//  AGC_WIN   1024   samples per AGC window; power of 2, >=16
//  AGC_HYST  32     deadband on magnitude-bit count, in counts
//  THR_INIT  2048   threshold after reset, 16-bit unsigned
//  THR_MIN   64     AGC lower clamp
//  THR_MAX   30000  AGC upper clamp
// PORTS
//  clk         in   1   system clock
//  rstn        in   1   asynchronous active-low reset
//  dv_in       in   1   input sample strobe
//  real_in     in   16  signed I sample
//  imag_in     in   16  signed Q sample
//  agc_en      in   1   1: AGC drives threshold; 0: thr_manual is used
//  thr_manual  in   16  manual threshold, unsigned
//  mag_target  in   16  target count of set mag bits per window (max 2*AGC_WIN)
//  q_dv        out  1   quantized tap strobe
//  q_real      out  2   {sign,mag} of I
//  q_imag      out  2   {sign,mag} of Q
//  m_valid     out  1   packed word valid
//  m_ready     in   1   sink ready
//  m_data      out  32  packed word
//  thr_out     out  16  threshold currently applied
//  overflow    out  1   sticky: a completed word was dropped
//  ovf_clr     in   1   clears overflow and drop_cnt
//  drop_cnt    out  16  dropped-word count, saturates at 0xFFFF
// BEHAVIOUR
//  Reset: all outputs 0 except thr_out=THR_INIT. Pack index, partial word, AGC counters cleared.
//  Quantize (1 cycle, on dv_in):
//   - sign = x[15].
//   - mag = (|x| >= thr), with |x| computed in 17 bits, so -32768 gives 32768.
//   - q_dv=dv_in delayed 1 cycle. q_real/q_imag hold their values between strobes.
//  Pack:
//   - nibble = {i_sign,i_mag,q_sign,q_mag}.
//   - Sample k (k=0..7) goes to bits [4k+3:4k].
//   - 3-bit index wraps 7->0.
//   - The 8th sample's dv_in at cycle t gives m_valid=1 at t+2.
//  Handshake:
//   - Transfer when m_valid&&m_ready. m_data is stable while m_valid&&!m_ready.
//   - m_valid drops the cycle after the transfer unless a new word loads the same cycle.
//   - A word completing while the output register is occupied and not transferring
//     is dropped: overflow<=1, drop_cnt++.
//   - Packing continues regardless of backpressure; no input stall exists.
//   - ovf_clr coincident with a new drop: overflow stays 1 and drop_cnt=1.
//  AGC (agc_en=1):
//   - cnt accumulates i_mag+q_mag over AGC_WIN strobes.
//   - At the window end:
//     - cnt > mag_target+AGC_HYST: thr += thr>>4
//     - cnt < mag_target-AGC_HYST: thr -= thr>>4
//     - otherwise thr is unchanged.
//   - The result is clamped to [THR_MIN,THR_MAX].
//   - The new thr applies from the next strobe after the window's last sample.
//   - mag_target-AGC_HYST is floored at 0.
//  agc_en=0:
//   - thr=thr_manual, effective next cycle.
//   - Window counters are held at 0.
//   - AGC register is loaded with thr_manual so re-enable is bumpless.
//  agc_en 0->1 starts a fresh window.
//  rstn asserted mid-word discards the partial word. The first post-reset sample is index 0.
// STRUCTURE
//  Shared package gps_sim_pkg:
//   - typedef quant2_t {logic sign; logic mag;}
//   - localparam SAMPLES_PER_WORD=8
//   - localparam PACK_W=32
//  Sub-module agc_threshold: window counter, accumulator, step/clamp, manual mux; output thr.
//  Quantizer, packer and output register live in bb_quant_pack.
// TESTING
//  1 Reset:
//    - rstn=0 -> m_valid=0, overflow=0, drop_cnt=0, thr_out=2048.
//    - Release rstn, no dv_in -> no outputs change.
//  2 Pack:
//    - agc_en=0, thr_manual=100, Q=0.
//    - I = 150,-150,50,-50,0,-100,99,100 -> m_data=0x40C080C4, m_valid 2 cycles after the 8th strobe.
//  3 Edge:
//    - thr_manual=32767, I=-32768 -> q_real=2'b11.
//    - I=32767 -> q_real=2'b01.
//  4 Backpressure:
//    - m_ready=0 over 24 strobes -> first word held, 2 dropped, overflow=1, drop_cnt=2.
//    - ovf_clr -> overflow=0, drop_cnt=0.
//  5 AGC:
//    - AGC_WIN=16, mag_target=10, AGC_HYST=2, constant I=Q=+1000.
//    - Expect: thr 2048 falls by >>4 steps per window to <=1000, then oscillates within [939,1063].
//    - Check: thr_out never < THR_MIN.
//  6 Mid-word reset:
//    - rstn pulse after 5 strobes.
//    - Next 8 strobes yield exactly one word, built from the post-reset samples only.

Source files
------------

// File: rtl/bb_quant_pack_pkg.sv
// Package gps_sim_pkg: types and constants shared by the baseband quantizer/packer slice.
//   quant2_t          : 2-bit sign/magnitude sample {sign, mag}
//   SAMPLES_PER_WORD  : complex samples packed per output word
//   PACK_W            : packed output word width
//   quantize()        : sign/magnitude quantization of one 16-bit rail against a threshold
package gps_sim_pkg;

  localparam int SAMPLES_PER_WORD = 8;
  localparam int PACK_W           = 32;

  typedef struct packed {
    logic sign;
    logic mag;
  } quant2_t;

  // The magnitude is formed in 17 bits so that -32768 maps to +32768 and
  // therefore always compares as the largest possible magnitude.
  function automatic quant2_t quantize(input logic [15:0] x, input logic [15:0] thr);
    quant2_t     q;
    logic [16:0] xs;
    logic [16:0] ax;
    xs     = {x[15], x};
    ax     = x[15] ? (17'd0 - xs) : xs;
    q.sign = x[15];
    q.mag  = (ax >= {1'b0, thr});
    return q;
  endfunction

endpackage

// File: rtl/bb_quant_pack_if.sv
// Packed-word valid/ready stream from bb_quant_pack to the capture FIFO/DMA.
//   m_valid : packed word valid (source -> sink)
//   m_ready : sink ready        (sink -> source)
//   m_data  : packed word       (source -> sink)
// Modports: master = word source, slave = word sink.
interface bb_quant_pack_if
  import gps_sim_pkg::*;
();

  logic              m_valid;
  logic              m_ready;
  logic [PACK_W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/bb_quant_pack_agc_threshold.sv
// agc_threshold: magnitude-threshold control for the 2-bit quantizer.
//   clk, rstn   : clock, asynchronous active-low reset
//   agc_en      : 1 = closed-loop AGC, 0 = thr follows thr_manual
//   thr_manual  : manual threshold
//   mag_target  : wanted count of set magnitude bits per window
//   strobe      : a sample is being quantized this cycle
//   i_mag/q_mag : magnitude bits of that sample (computed with the current thr)
//   thr         : threshold currently applied
module agc_threshold
  import gps_sim_pkg::*;
#(
  parameter int AGC_WIN  = 1024,
  parameter int AGC_HYST = 32,
  parameter int THR_INIT = 2048,
  parameter int THR_MIN  = 64,
  parameter int THR_MAX  = 30000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        agc_en,
  input  logic [15:0] thr_manual,
  input  logic [15:0] mag_target,
  input  logic        strobe,
  input  logic        i_mag,
  input  logic        q_mag,
  output logic [15:0] thr
);

  localparam int WIN_W = $clog2(AGC_WIN);
  localparam int ACC_W = WIN_W + 2;  // holds up to 2*AGC_WIN

  logic [WIN_W-1:0] win_cnt_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic [15:0]      thr_reg;
  logic [15:0]      thr_step;
  logic [16:0]      thr_up;
  logic [15:0]      thr_dn;
  logic [16:0]      thr_raw;
  logic [17:0]      cnt_ext;
  logic [17:0]      hi_lim;
  logic [17:0]      lo_lim;
  logic             win_end;

  // The current sample is included, so the window decision is made in the
  // same cycle as its last strobe and the next strobe sees the new threshold.
  assign acc_next = acc_reg + ACC_W'(i_mag) + ACC_W'(q_mag);
  assign cnt_ext  = 18'(acc_next);
  assign hi_lim   = {2'b00, mag_target} + 18'(AGC_HYST);
  assign lo_lim   = (mag_target >= 16'(AGC_HYST)) ? {2'b00, mag_target - 16'(AGC_HYST)} : 18'd0;
  assign thr_up   = {1'b0, thr_reg} + {5'b00000, thr_reg[15:4]};
  assign thr_dn   = thr_reg - {4'b0000, thr_reg[15:4]};
  assign win_end  = (win_cnt_reg == WIN_W'(AGC_WIN - 1));

  always_comb begin
    thr_raw = {1'b0, thr_reg};
    if (cnt_ext > hi_lim) begin
      thr_raw = thr_up;
    end else if (cnt_ext < lo_lim) begin
      thr_raw = {1'b0, thr_dn};
    end
  end

  // Clamp applies to every window result, including an unchanged one that a
  // manual value outside the range carried over at re-enable.
  always_comb begin
    thr_step = thr_raw[15:0];
    if (thr_raw > 17'(THR_MAX)) begin
      thr_step = 16'(THR_MAX);
    end else if (thr_raw < 17'(THR_MIN)) begin
      thr_step = 16'(THR_MIN);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      thr_reg     <= 16'(THR_INIT);
      win_cnt_reg <= '0;
      acc_reg     <= '0;
    end else if (!agc_en) begin
      // Tracking thr_manual here makes re-enable bumpless; holding the
      // counters at zero makes the first enabled strobe open a fresh window.
      thr_reg     <= thr_manual;
      win_cnt_reg <= '0;
      acc_reg     <= '0;
    end else if (strobe) begin
      if (win_end) begin
        thr_reg     <= thr_step;
        win_cnt_reg <= '0;
        acc_reg     <= '0;
      end else begin
        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
        acc_reg     <= acc_next;
      end
    end
  end

  assign thr = thr_reg;

endmodule

// File: rtl/bb_quant_pack.sv
// bb_quant_pack: 2-bit sign/magnitude quantizer, AGC and 8-sample word packer.
//   clk, rstn          : clock, asynchronous active-low reset
//   dv_in, real_in,
//   imag_in            : 16-bit signed complex input samples with strobe
//   agc_en, thr_manual,
//   mag_target         : threshold control (see agc_threshold)
//   q_dv, q_real,
//   q_imag             : unpacked {sign,mag} tap, one cycle after dv_in
//   m_if (master)      : packed 32-bit word stream, valid/ready
//   thr_out            : threshold currently applied
//   overflow, drop_cnt : sticky drop flag and saturating dropped-word count
//   ovf_clr            : clears overflow and drop_cnt
module bb_quant_pack
  import gps_sim_pkg::*;
#(
  parameter int AGC_WIN  = 1024,
  parameter int AGC_HYST = 32,
  parameter int THR_INIT = 2048,
  parameter int THR_MIN  = 64,
  parameter int THR_MAX  = 30000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dv_in,
  input  logic [15:0]       real_in,
  input  logic [15:0]       imag_in,
  input  logic              agc_en,
  input  logic [15:0]       thr_manual,
  input  logic [15:0]       mag_target,
  output logic              q_dv,
  output logic [1:0]        q_real,
  output logic [1:0]        q_imag,
  bb_quant_pack_if.master   m_if,
  output logic [15:0]       thr_out,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [15:0]       drop_cnt
);

  localparam int NIB_W  = PACK_W / SAMPLES_PER_WORD;
  localparam int IDX_W  = $clog2(SAMPLES_PER_WORD);
  localparam int PART_W = (SAMPLES_PER_WORD - 1) * NIB_W;

  quant2_t           qi_now;
  quant2_t           qq_now;
  quant2_t           qi_reg;
  quant2_t           qq_reg;
  logic              q_dv_reg;
  logic [15:0]       thr_cur;
  logic [NIB_W-1:0]  nibble;
  logic [IDX_W-1:0]  idx_reg;
  logic [PART_W-1:0] partial_reg;
  logic [PART_W-1:0] partial_next;
  logic [PACK_W-1:0] full_word;
  logic              word_done;
  logic              m_valid_reg;
  logic [PACK_W-1:0] m_data_reg;
  logic              take;
  logic              drop;
  logic              overflow_reg;
  logic [15:0]       drop_cnt_reg;

  // ---------------- threshold ----------------
  agc_threshold #(
    .AGC_WIN  (AGC_WIN),
    .AGC_HYST (AGC_HYST),
    .THR_INIT (THR_INIT),
    .THR_MIN  (THR_MIN),
    .THR_MAX  (THR_MAX)
  ) u_agc (
    .clk        (clk),
    .rstn       (rstn),
    .agc_en     (agc_en),
    .thr_manual (thr_manual),
    .mag_target (mag_target),
    .strobe     (dv_in),
    .i_mag      (qi_now.mag),
    .q_mag      (qq_now.mag),
    .thr        (thr_cur)
  );

  // ---------------- quantizer ----------------
  assign qi_now = quantize(real_in, thr_cur);
  assign qq_now = quantize(imag_in, thr_cur);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_dv_reg <= 1'b0;
      qi_reg   <= '0;
      qq_reg   <= '0;
    end else begin
      q_dv_reg <= dv_in;
      if (dv_in) begin
        qi_reg <= qi_now;
        qq_reg <= qq_now;
      end
    end
  end

  // ---------------- packer ----------------
  assign nibble    = {qi_reg, qq_reg};
  assign word_done = q_dv_reg && (idx_reg == IDX_W'(SAMPLES_PER_WORD - 1));
  // The last sample of a word bypasses the partial register straight into
  // the output register, giving the two-cycle dv_in -> m_valid latency.
  assign full_word = {nibble, partial_reg};

  genvar gi;
  generate
    for (gi = 0; gi < SAMPLES_PER_WORD - 1; gi++) begin : g_lane
      assign partial_next[NIB_W*gi +: NIB_W] =
        (q_dv_reg && (idx_reg == IDX_W'(gi))) ? nibble : partial_reg[NIB_W*gi +: NIB_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_reg     <= '0;
      partial_reg <= '0;
    end else begin
      partial_reg <= partial_next;
      if (q_dv_reg) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end
  end

  // ---------------- output register ----------------
  assign take = m_valid_reg && m_if.m_ready;
  // Packing never stalls: a word finishing while the held word is not
  // leaving this cycle has nowhere to go and is counted as dropped.
  assign drop = word_done && m_valid_reg && !m_if.m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else if (word_done && !drop) begin
      m_valid_reg <= 1'b1;
      m_data_reg  <= full_word;
    end else if (take) begin
      m_valid_reg <= 1'b0;
    end
  end

  // A clear coinciding with a drop restarts the count at that drop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (ovf_clr) begin
        drop_cnt_reg <= 16'd1;
      end else if (drop_cnt_reg != 16'hFFFF) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

  assign q_dv        = q_dv_reg;
  assign q_real      = qi_reg;
  assign q_imag      = qq_reg;
  assign m_if.m_valid = m_valid_reg;
  assign m_if.m_data  = m_data_reg;
  assign thr_out     = thr_cur;
  assign overflow    = overflow_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_bb_quant_pack.sv
// Scoreboard bench for bb_quant_pack: stimulus pushes expected taps/words,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_bb_quant_pack;

  localparam int AGC_WIN  = 16;
  localparam int AGC_HYST = 2;
  localparam int THR_INIT = 2048;
  localparam int THR_MIN  = 64;
  localparam int THR_MAX  = 30000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dv_in = 1'b0;
  logic [15:0] real_in = '0;
  logic [15:0] imag_in = '0;
  logic        agc_en = 1'b1;
  logic [15:0] thr_manual = 16'd2048;
  logic [15:0] mag_target = 16'd10;
  logic        ovf_clr = 1'b0;
  logic        q_dv;
  logic [1:0]  q_real;
  logic [1:0]  q_imag;
  logic [15:0] thr_out;
  logic        overflow;
  logic [15:0] drop_cnt;

  bb_quant_pack_if sif ();

  bb_quant_pack #(
    .AGC_WIN (AGC_WIN), .AGC_HYST (AGC_HYST), .THR_INIT (THR_INIT),
    .THR_MIN (THR_MIN), .THR_MAX (THR_MAX)
  ) dut (
    .clk (clk), .rstn (rstn), .dv_in (dv_in), .real_in (real_in), .imag_in (imag_in),
    .agc_en (agc_en), .thr_manual (thr_manual), .mag_target (mag_target),
    .q_dv (q_dv), .q_real (q_real), .q_imag (q_imag), .m_if (sif.master),
    .thr_out (thr_out), .overflow (overflow), .ovf_clr (ovf_clr), .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [3:0]  exp_q[$];
  logic [31:0] exp_w[$];
  int          model_thr = THR_INIT;
  bit          model_agc = 1'b1;
  int          win_n = 0;
  int          win_cnt = 0;
  int          pidx = 0;
  logic [31:0] pword = '0;
  bit          slot_full = 1'b0;
  int          model_drops = 0;
  int          words_seen = 0;
  logic [31:0] last_word = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  int          vals[8] = '{150, -150, 50, -50, 0, -100, 99, 100};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit mag_of(input int x, input int thr);
    int a;
    a = (x < 0) ? -x : x;
    return a >= thr;
  endfunction

  function automatic int rsamp(input int span);
    logic [15:0] r;
    int          sel;
    sel = $urandom_range(0, 5);
    r = 16'($urandom);
    if (sel == 0) return int'($signed(r));
    if (sel == 1) return (($urandom % 2) == 0) ? -32768 : 32767;
    return int'($urandom_range(0, 2 * span)) - span;
  endfunction

  task automatic send(input int re, input int im);
    bit         mi, mq;
    logic [3:0] nib;
    int         lo;
    @(posedge clk); #1;
    check("thr_applied", thr_out, model_thr);
    mi  = mag_of(re, model_thr);
    mq  = mag_of(im, model_thr);
    nib = {re < 0, mi, im < 0, mq};
    exp_q.push_back(nib);
    pword = pword | (32'(nib) << (4 * pidx));
    pidx++;
    if (pidx == 8) begin
      if (slot_full && !sif.m_ready) model_drops++;
      else begin
        exp_w.push_back(pword);
        if (!sif.m_ready) slot_full = 1'b1;
      end
      pidx  = 0;
      pword = '0;
    end
    if (model_agc) begin
      win_cnt += int'(mi) + int'(mq);
      win_n++;
      if (win_n == AGC_WIN) begin
        lo = int'(mag_target) - AGC_HYST;
        if (lo < 0) lo = 0;
        if (win_cnt > int'(mag_target) + AGC_HYST) model_thr = model_thr + model_thr / 16;
        else if (win_cnt < lo) model_thr = model_thr - model_thr / 16;
        if (model_thr > THR_MAX) model_thr = THR_MAX;
        if (model_thr < THR_MIN) model_thr = THR_MIN;
        win_n   = 0;
        win_cnt = 0;
      end
    end
    real_in = 16'(re);
    imag_in = 16'(im);
    dv_in   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      dv_in = 1'b0;
    end
  endtask

  task automatic set_agc(input bit en, input int manual, input int target);
    @(posedge clk); #1;
    dv_in      = 1'b0;
    agc_en     = en;
    thr_manual = 16'(manual);
    mag_target = 16'(target);
    model_agc  = en;
    if (!en) begin
      win_n   = 0;
      win_cnt = 0;
    end
    @(posedge clk); #1;
    if (!en) model_thr = manual;
  endtask

  task automatic do_reset();
    idle(3);
    check("drain_taps", exp_q.size(), 0);
    check("drain_words", exp_w.size(), 0);
    rstn = 1'b0;
    exp_q.delete();
    exp_w.delete();
    pidx = 0; pword = '0; model_thr = THR_INIT; win_n = 0; win_cnt = 0;
    slot_full = 1'b0; model_drops = 0;
    @(negedge clk);
    check("rst_m_valid", sif.m_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_thr", thr_out, THR_INIT);
    check("rst_q_dv", q_dv, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    if (!agc_en) model_thr = int'(thr_manual);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (q_dv) begin
        if (exp_q.size() == 0) check("tap_unexpected", 1, 0);
        else check("tap", {q_real, q_imag}, exp_q.pop_front());
      end
      if (prev_stall) begin
        check("stall_valid", sif.m_valid, 1);
        check("stall_data", sif.m_data, prev_data);
      end
      if (sif.m_valid && sif.m_ready) begin
        words_seen++;
        last_word = sif.m_data;
        if (exp_w.size() == 0) check("word_unexpected", 1, 0);
        else check("word", sif.m_data, exp_w.pop_front());
      end
      prev_stall = sif.m_valid && !sif.m_ready;
      prev_data  = sif.m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog cycles=80000 required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws;
    sif.m_ready = 1'b1;
    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", sif.m_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_thr", thr_out, THR_INIT);
    check("rst_m_data", sif.m_data, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_thr", thr_out, THR_INIT);
      check("idle_valid", sif.m_valid, 0);
      check("idle_q_dv", q_dv, 0);
    end

    // 2: pack vector and latency
    set_agc(1'b0, 100, 10);
    for (int k = 0; k < 8; k++) send(vals[k], 0);
    @(posedge clk); #1;
    dv_in = 1'b0;
    @(negedge clk);
    check("latency_t1", sif.m_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("latency_t2", sif.m_valid, 1);
    check("pack_vector", sif.m_data, 32'h40C080C4);

    // 3: magnitude edges
    set_agc(1'b0, 32767, 10);
    send(-32768, 0);
    idle(1);
    @(negedge clk);
    check("edge_neg_full", q_real, 2'b11);
    send(32767, 0);
    idle(1);
    @(negedge clk);
    check("edge_pos_max", q_real, 2'b01);

    // random manual thresholds with gaps
    for (int r = 0; r < 4; r++) begin
      set_agc(1'b0, int'($urandom_range(0, 4000)), 10);
      for (int n = 0; n < 40; n++) begin
        if (($urandom % 4) == 0) idle(1);
        send(rsamp(3000), rsamp(3000));
      end
    end

    // 4: backpressure, drops, clear
    while (pidx != 0) send(rsamp(3000), rsamp(3000));
    idle(4);
    sif.m_ready = 1'b0;
    for (int n = 0; n < 24; n++) send(rsamp(3000), rsamp(3000));
    idle(4);
    check("bp_overflow", overflow, 1);
    check("bp_drop_cnt", drop_cnt, 32'(model_drops));
    model_drops = 0;
    for (int n = 0; n < 8; n++) send(rsamp(3000), rsamp(3000));
    @(posedge clk); #1;
    dv_in = 1'b0;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_coincident_ovf", overflow, 1);
    check("clr_coincident_cnt", drop_cnt, 32'(model_drops));
    @(posedge clk); #1;
    sif.m_ready = 1'b1;
    slot_full = 1'b0;
    idle(2);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    model_drops = 0;
    @(negedge clk);
    check("clr_overflow", overflow, 0);
    check("clr_drop_cnt", drop_cnt, 32'(model_drops));

    // 5: AGC convergence from reset
    @(posedge clk); #1;
    agc_en = 1'b1;
    model_agc = 1'b1;
    mag_target = 16'd10;
    do_reset();
    for (int k = 0; k < 40 * AGC_WIN; k++) begin
      if ((k % AGC_WIN) == 0) begin
        @(negedge clk);
        check("agc_floor", thr_out >= 16'(THR_MIN), 1);
        if (k >= 12 * AGC_WIN)
          check("agc_band", (thr_out >= 16'd939) && (thr_out <= 16'd1063), 1);
      end
      send(1000, 1000);
    end

    // random AGC runs, each re-entered from manual
    for (int r = 0; r < 3; r++) begin
      set_agc(1'b0, int'($urandom_range(64, 3000)), int'($urandom_range(0, 32)));
      set_agc(1'b1, int'(thr_manual), int'(mag_target));
      for (int n = 0; n < 160; n++) begin
        if (($urandom % 5) == 0) idle(1);
        send(rsamp(2500), rsamp(2500));
      end
    end

    // 6: mid-word reset
    set_agc(1'b0, 100, 10);
    while (pidx != 0) send(rsamp(3000), rsamp(3000));
    for (int n = 0; n < 5; n++) send(-1000, -1000);
    do_reset();
    ws = words_seen;
    for (int k = 0; k < 8; k++) send(vals[k], 0);
    idle(4);
    check("post_reset_words", words_seen - ws, 1);
    check("post_reset_word", last_word, 32'h40C080C4);

    idle(4);
    check("final_taps", exp_q.size(), 0);
    check("final_words", exp_w.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
